// File: rtl/uart_pkg.sv
// Shared frame constants and FSM state encoding for the UART echo block.
// Both RX and TX walk the same four-phase frame.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  typedef struct packed {
    logic                 vld;
    logic [DATA_BITS-1:0] data;
  } rx_byte_t;

  // Bit-period counter width for a given half-bit length.
  function automatic int cnt_w(input int half);
    return $clog2(2 * half);
  endfunction

endpackage

// File: rtl/uart_tx_core.sv
// 8N1 serialiser. txd is a register that trails the state by one cycle, so
// each accepted byte appears on the line one cycle after it is taken.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int CLK_PER_HALF_BIT = 85
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 start,
  output logic                 busy,
  output logic                 txd
);

  localparam int BIT_CYC = 2 * CLK_PER_HALF_BIT;
  localparam int CW      = cnt_w(CLK_PER_HALF_BIT);
  localparam int BW      = $clog2(DATA_BITS);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS * BIT_CYC - 1);
  localparam logic [BW-1:0] IDX_LAST  = BW'(DATA_BITS - 1);

  uart_state_t          state;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 stop_end;

  assign stop_end = (state == STOP) && (cnt == STOP_LAST);
  // Ready in IDLE and on the last stop cycle, so queued bytes follow with no gap.
  assign busy     = !((state == IDLE) || stop_end);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
      txd   <= 1'b1;
    end else begin
      unique case (state)
        START:   txd <= 1'b0;
        DATA:    txd <= shreg[0];
        default: txd <= 1'b1;
      endcase

      unique case (state)
        IDLE: begin
          if (start) begin
            shreg <= data;
            cnt   <= '0;
            state <= START;
          end
        end
        START: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            idx   <= '0;
            state <= DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            shreg <= shreg >> 1;
            if (idx == IDX_LAST) state <= STOP;
            else                 idx   <= idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (stop_end) begin
            cnt <= '0;
            if (start) begin
              shreg <= data;
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_echo_loopback.sv
// UART echo: synchronised 8N1 receiver feeding a 2-deep holding buffer that
// drains into uart_tx_core, giving a ~9.5-bit-delayed copy of rxd on txd.
module uart_echo_loopback
  import uart_pkg::*;
#(
  parameter int CLK_PER_HALF_BIT = 85
) (
  input  logic rxd,
  output logic txd,
  input  logic clk,
  input  logic rst
);

  localparam int BIT_CYC = 2 * CLK_PER_HALF_BIT;
  localparam int CW      = cnt_w(CLK_PER_HALF_BIT);
  localparam int BW      = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_PER_HALF_BIT - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYC - 1);
  localparam logic [BW-1:0] IDX_LAST  = BW'(DATA_BITS - 1);

  // rxd_d holds the previous synchronised sample for falling-edge detection.
  logic [1:0] rxd_sync;
  logic       rxd_s, rxd_d;

  assign rxd_s = rxd_sync[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_sync <= 2'b11;
      rxd_d    <= 1'b1;
    end else begin
      rxd_sync <= {rxd_sync[0], rxd};
      rxd_d    <= rxd_s;
    end
  end

  uart_state_t          rx_state;
  logic [CW-1:0]        rx_cnt;
  logic [BW-1:0]        rx_idx;
  logic [DATA_BITS-1:0] rx_shreg;
  rx_byte_t             rx_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state <= IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shreg <= '0;
      rx_out   <= '0;
    end else begin
      rx_out.vld <= 1'b0;
      unique case (rx_state)
        IDLE: begin
          if (!rxd_s && rxd_d) begin
            rx_cnt   <= '0;
            rx_state <= START;
          end
        end
        START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_state <= rxd_s ? IDLE : DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_shreg <= {rxd_s, rx_shreg[DATA_BITS-1:1]};
            if (rx_idx == IDX_LAST) rx_state <= STOP;
            else                    rx_idx   <= rx_idx + 1'b1;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        STOP: begin
          // Back to IDLE at the stop centre so an immediate next start edge is seen.
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_state <= IDLE;
            if (rxd_s) begin
              rx_out.vld  <= 1'b1;
              rx_out.data <= rx_shreg;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_state <= IDLE;
      endcase
    end
  end

  logic [1:0][DATA_BITS-1:0] fifo_mem;
  logic                      wr_ptr, rd_ptr;
  logic [1:0]                fifo_cnt;
  logic                      overflow;
  logic                      fifo_full, fifo_empty, push, push_ok, pop;
  logic                      tx_busy;

  assign fifo_full  = (fifo_cnt == 2'd2);
  assign fifo_empty = (fifo_cnt == 2'd0);
  assign push       = rx_out.vld;
  assign pop        = !fifo_empty && !tx_busy;
  // A pop in the same cycle frees the slot, so a push into a full buffer still lands.
  assign push_ok    = push && (!fifo_full || pop);

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= rx_out.data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
      overflow <= 1'b0;
    end else begin
      if (push_ok)         wr_ptr   <= ~wr_ptr;
      if (pop)             rd_ptr   <= ~rd_ptr;
      if (push && !push_ok) overflow <= 1'b1;
      unique case ({push_ok, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  uart_tx_core #(
    .CLK_PER_HALF_BIT(CLK_PER_HALF_BIT)
  ) u_tx (
    .clk   (clk),
    .rst   (rst),
    .data  (fifo_mem[rd_ptr]),
    .start (!fifo_empty),
    .busy  (tx_busy),
    .txd   (txd)
  );

endmodule

// File: tb/tb_uart_echo_loopback.sv
// Scoreboarded bench: two echo instances (half-bit 85 and 4), serial drivers on
// rxd, and frame monitors on txd that pop and compare expected bytes.
module tb_uart_echo_loopback;
  import uart_pkg::*;

  localparam int H  = 85;
  localparam int H4 = 4;

  logic clk = 1'b0;
  logic rst = 1'b1, rst4 = 1'b1;
  logic rxd = 1'b1, rxd4 = 1'b1;
  logic txd, txd4;

  always #5 clk = ~clk;

  uart_echo_loopback #(.CLK_PER_HALF_BIT(H)) dut (
    .rxd(rxd), .txd(txd), .clk(clk), .rst(rst)
  );
  uart_echo_loopback #(.CLK_PER_HALF_BIT(H4)) dut4 (
    .rxd(rxd4), .txd(txd4), .clk(clk), .rst(rst4)
  );

  int   n_chk = 0, n_fail = 0;
  logic [7:0] exp_q[$], exp4_q[$];
  int   frames = 0, frames4 = 0;
  time  t_txfall = 0, t_rxfall = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic line(input bit sel);
    return sel ? txd4 : txd;
  endfunction

  task automatic wait_n(input bit sel, input int n, output bit abort);
    abort = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (sel ? rst4 : rst) abort = 1'b1;
    end
  endtask

  // Decode txd frames at bit centres; a reset mid-frame abandons the frame.
  task automatic mon(input bit sel);
    int         h = sel ? H4 : H;
    string      pfx = sel ? "d4" : "d85";
    logic [7:0] b;
    logic [7:0] e;
    bit         ab;
    forever begin
      @(negedge clk);
      if ((sel ? rst4 : rst) || line(sel) !== 1'b0) continue;
      if (!sel) t_txfall = $time;
      wait_n(sel, h, ab);
      if (ab) continue;
      chk($sformatf("%s_start_bit", pfx), line(sel), 0);
      for (int i = 0; i < 8; i++) begin
        wait_n(sel, 2*h, ab);
        if (ab) break;
        b[i] = line(sel);
      end
      if (ab) continue;
      wait_n(sel, 2*h, ab);
      if (ab) continue;
      chk($sformatf("%s_stop_bit", pfx), line(sel), 1);
      if (sel) begin
        chk("d4_expected_pending", exp4_q.size() > 0, 1);
        if (exp4_q.size() > 0) begin
          e = exp4_q.pop_front();
          chk("d4_byte", b, e);
        end
        frames4++;
      end else begin
        chk("d85_expected_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("d85_byte", b, e);
        end
        frames++;
      end
    end
  endtask

  initial mon(1'b0);
  initial mon(1'b1);

  // Called aligned 1 unit after a rising edge; returns aligned the same way.
  task automatic send(input bit sel, input logic [7:0] d, input logic stop);
    int         bc = sel ? 2*H4 : 2*H;
    logic [9:0] fr;
    fr = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      if (sel) rxd4 = fr[i];
      else     rxd  = fr[i];
      if (i == 0 && !sel) t_rxfall = $time;
      repeat (bc) @(posedge clk);
      #1;
    end
  endtask

  task automatic tx_byte(input bit sel, input logic [7:0] d);
    if (sel) exp4_q.push_back(d);
    else     exp_q.push_back(d);
    send(sel, d, 1'b1);
  endtask

  task automatic drain(input bit sel, input string tag);
    int n = 0;
    while ((sel ? exp4_q.size() : exp_q.size()) != 0 && n < 40000) begin
      @(posedge clk);
      n++;
    end
    chk(tag, sel ? exp4_q.size() : exp_q.size(), 0);
    repeat ((sel ? H4 : H) + 4) @(posedge clk);
    #1;
  endtask

  task automatic count_lows(input bit sel, input int n, output int lows);
    lows = 0;
    repeat (n) begin
      @(negedge clk);
      if (line(sel) == 1'b0) lows++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic low_run(output int n);
    int w = 0;
    n = 0;
    while (txd4 !== 1'b0 && w < 2000) begin @(negedge clk); w++; end
    while (txd4 === 1'b0 && n < 2000) begin @(negedge clk); n++; end
  endtask

  initial begin
    #(10 * 90000);
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    string      s_long, s_short;
    int         lows, f0, n, r0, r1;
    time        t0, target;
    s_long  = "The quick brown fox jumps over the lazy dog";
    s_short = "The quick";

    repeat (3) @(posedge clk);
    #1;
    chk("rst_txd", txd, 1);
    chk("rst_txd4", txd4, 1);
    chk("rst_rx_idle", dut.rx_state == IDLE, 1);
    chk("rst_fifo_empty", dut.fifo_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    rst4 = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Single byte with end-to-end latency measured from rxd fall to txd fall.
    chk("idle_before_T", txd, 1);
    tx_byte(1'b0, 8'h54);
    drain(1'b0, "T_drained");
    chk("T_latency_cycles", 32'((t_txfall - t_rxfall) / 10), 19*H + 6);
    chk("idle_after_T", txd, 1);

    // Back-to-back burst: last frame must keep the same latency (no added gaps).
    for (int i = 0; i < s_short.len(); i++) tx_byte(1'b0, s_short[i]);
    drain(1'b0, "burst_drained");
    chk("burst_last_latency", 32'((t_txfall - t_rxfall) / 10), 19*H + 6);
    chk("burst_no_overflow", dut.overflow, 0);

    // Start-bit glitch shorter than half a bit.
    f0 = frames;
    rxd = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    rxd = 1'b1;
    count_lows(1'b0, 12*2*H, lows);
    chk("glitch_txd_quiet", lows, 0);
    chk("glitch_no_frame", frames, f0);
    chk("glitch_rx_idle", dut.rx_state == IDLE, 1);

    // Framing error is dropped; the following byte echoes.
    f0 = frames;
    send(1'b0, 8'hA5, 1'b0);
    rxd = 1'b1;
    count_lows(1'b0, 12*2*H, lows);
    chk("frame_err_txd_quiet", lows, 0);
    chk("frame_err_no_frame", frames, f0);
    tx_byte(1'b0, 8'h3C);
    drain(1'b0, "after_frame_err_drained");

    // Reset during TX data bit 4 (bit 4 of 8'hC3 is 0).
    t0 = t_txfall;
    send(1'b0, 8'hC3, 1'b1);
    n = 0;
    while (t_txfall == t0 && n < 4000) begin @(posedge clk); n++; end
    chk("rst_test_tx_started", t_txfall != t0, 1);
    target = (t_txfall - 5) + 10 * (5*2*H + H) + 3;
    if (target > $time) #(target - $time);
    chk("pre_rst_txd_low", txd, 0);
    rst = 1'b1;
    #1;
    chk("rst_txd_async_high", txd, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    count_lows(1'b0, 12*2*H, lows);
    chk("no_partial_resume", lows, 0);
    chk("post_rst_overflow_clear", dut.overflow, 0);
    tx_byte(1'b0, 8'h41);
    drain(1'b0, "after_rst_drained");

    // Minimum half-bit: FF then 00 back-to-back, exact bit widths on txd4.
    fork
      begin
        tx_byte(1'b1, 8'hFF);
        tx_byte(1'b1, 8'h00);
      end
      begin
        low_run(r0);
        low_run(r1);
      end
    join
    chk("d4_start_width", r0, 8);
    chk("d4_zero_run_width", r1, 72);
    drain(1'b1, "d4_ff00_drained");

    // Full pangram stream on the fast instance.
    f0 = frames4;
    for (int i = 0; i < s_long.len(); i++) tx_byte(1'b1, s_long[i]);
    drain(1'b1, "d4_stream_drained");
    chk("d4_stream_frames", frames4 - f0, 43);
    chk("d4_stream_no_overflow", dut4.overflow, 0);
    chk("d4_idle_after_stream", txd4, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
